// File: rtl/mux4_sel_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux4_sel_arb
// Purpose  : Round-robin arbiter driving the 2-bit select of a 4->1 mux.
//            Optional forced rotation via MUX4_SEL_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_sel_arb #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] w_sel_nxt;
    logic [3:0] w_gnt_nxt;
    logic       w_busy_nxt;
    logic [1:0] w_win;
    logic [1:0] w_cand;
    logic       w_found;
    logic       w_timeout_hit;
    logic       w_release;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("mux4_sel_arb: HOLD_MAX must be within 1..255");
    end

`ifdef MUX4_SEL_ARB_TIMEOUT_EN
    localparam logic [7:0] c_hold_last = 8'(HOLD_MAX - 1);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    assign w_timeout_hit = (r_cnt == c_hold_last);
    assign timeout       = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout       = 1'b0;
`endif

    // Search starts just past the last holder, so that holder is tried last.
    always_comb begin
        w_found = 1'b0;
        w_win   = sel;
        w_cand  = sel;
        for (int k = 1; k <= 4; k++) begin
            w_cand = sel + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_release = done || !req[sel] || w_timeout_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = sel;
        w_gnt_nxt   = gnt;
        w_busy_nxt  = busy;
`ifdef MUX4_SEL_ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_busy_nxt  = 1'b1;
`ifdef MUX4_SEL_ARB_TIMEOUT_EN
                    w_cnt_nxt   = 8'd0;
`endif
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_busy_nxt  = 1'b0;
`ifdef MUX4_SEL_ARB_TIMEOUT_EN
                    // Only a revocation with no voluntary release is reported.
                    w_timeout_nxt = !done && req[sel];
`endif
                end else begin
`ifdef MUX4_SEL_ARB_TIMEOUT_EN
                    w_cnt_nxt = r_cnt + 8'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            sel     <= 2'b11;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            sel     <= w_sel_nxt;
            gnt     <= w_gnt_nxt;
            busy    <= w_busy_nxt;
        end
    end

`ifdef MUX4_SEL_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux4_sel_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_sel_arb
// Purpose  : Scoreboard bench for mux4_sel_arb (either MUX4_SEL_ARB_TIMEOUT_EN build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_sel_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    mux4_sel_arb #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    wire [7:0] obs = {sel, gnt, busy, timeout};

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got sel=%0d gnt=%b busy=%b timeout=%b, want sel=%0d gnt=%b busy=%b timeout=%b",
                     tag, act[7:6], act[5:2], act[1], act[0], exp[7:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string tag, input logic [3:0] r, input logic d,
                        input logic [1:0] es, input logic [3:0] eg, input logic eb, input logic et);
        exp_t e;
        req   = r;
        done  = d;
        e.v   = {es, eg, eb, et};
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check(mon_e.tag, obs, mon_e.v);
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1 check("reset", obs, {2'b11, 4'b0000, 1'b0, 1'b0});
        #1 rst = 1'b0;

        // Full contention: rotation 0,1,2,3,0 with a guard cycle between grants
        step("rr_g0",   4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        step("rr_r0",   4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0);
        step("rr_g1",   4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("rr_r1",   4'b1111, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0);
        step("rr_g2",   4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
        step("rr_r2",   4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0);
        step("rr_g3",   4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0);
        step("rr_r3",   4'b1111, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0);
        step("rr_g0b",  4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        step("rr_r0b",  4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0);

        // Single requester, release by dropping req; sel holds in idle
        step("one_g2",   4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
        step("one_hold", 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
        step("one_drop", 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);
        step("one_idle", 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);

        // Wrap 3->0 and last holder lowest priority
        step("wrap_g3",  4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0);
        step("wrap_r3",  4'b1000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0);
        step("wrap_g0",  4'b1001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
        step("wrap_r0",  4'b1001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0);
        step("wrap_g3b", 4'b1001, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0);
        step("wrap_r3b", 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0);

        // Hold timer: four grant cycles, then forced release (timer builds only)
        step("to_c1",   4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("to_c2",   4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("to_c3",   4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("to_c4",   4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
`ifdef MUX4_SEL_ARB_TIMEOUT_EN
        step("to_rev",  4'b0010, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b1);
`else
        step("to_rev",  4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
`endif
        step("to_re1",  4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("to_re2",  4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("to_re3",  4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("to_re4",  4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("to_done", 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0);
        step("to_idle", 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0);

        // Asynchronous reset between edges mid-grant
        step("ar_g2",   4'b0110, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
        step("ar_hold", 4'b0110, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1 check("ar_async", obs, {2'b11, 4'b0000, 1'b0, 1'b0});
        @(posedge clk);
        #2 rst = 1'b0;
        step("ar_g1",   4'b0110, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0);
        step("ar_rel",  4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #3;
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
